// File: rtl/ram_write_arbiter.sv
// Two-writer arbiter for the single SDRAM write port of ram.
// Round-robin on ties, grant held for a whole burst, wr_done routed back to the owner only.
module ram_write_arbiter #(
  parameter int ADDR_WIDTH  = 23,
  parameter int DATA_WIDTH  = 32,
  parameter int MASK_WIDTH  = 4,
  parameter int BURST_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr0_request,
  input  logic [ADDR_WIDTH-1:0]  wr0_address,
  input  logic [DATA_WIDTH-1:0]  wr0_data,
  input  logic [MASK_WIDTH-1:0]  wr0_mask,
  input  logic [BURST_WIDTH-1:0] wr0_burst_length,
  output logic                   wr0_done,
  input  logic                   wr1_request,
  input  logic [ADDR_WIDTH-1:0]  wr1_address,
  input  logic [DATA_WIDTH-1:0]  wr1_data,
  input  logic [MASK_WIDTH-1:0]  wr1_mask,
  input  logic [BURST_WIDTH-1:0] wr1_burst_length,
  output logic                   wr1_done,
  output logic                   ram_wr_request,
  output logic [ADDR_WIDTH-1:0]  ram_wr_address,
  output logic [DATA_WIDTH-1:0]  ram_wr_data,
  output logic [MASK_WIDTH-1:0]  ram_wr_mask,
  output logic [BURST_WIDTH-1:0] ram_wr_burst_length,
  input  logic                   ram_wr_done,
  output logic                   busy,
  output logic                   owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   winner;
  logic   owner_req;
  logic   in_grant;

  // On a tie the writer that did not win last time gets the port.
  assign winner    = wr0_request ? (wr1_request ? ~last_grant : 1'b0) : 1'b1;
  assign owner_req = owner ? wr1_request : wr0_request;
  assign in_grant  = (state == GRANT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr0_request || wr1_request) begin
            owner      <= winner;
            last_grant <= winner;
            state      <= GRANT;
            busy       <= 1'b1;
          end
        end
        GRANT: begin
          // Completion wins over a same-cycle request drop; both end the grant.
          if (ram_wr_done || !owner_req) begin
            state <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_wr_request      = in_grant && owner_req;
  assign ram_wr_address      = owner ? wr1_address      : wr0_address;
  assign ram_wr_data         = owner ? wr1_data         : wr0_data;
  assign ram_wr_mask         = owner ? wr1_mask         : wr0_mask;
  assign ram_wr_burst_length = owner ? wr1_burst_length : wr0_burst_length;

  assign wr0_done = in_grant && ram_wr_done && !owner;
  assign wr1_done = in_grant && ram_wr_done &&  owner;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Randomized bench for ram_write_arbiter against a transaction-level reference model.
module tb_ram_write_arbiter;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int BW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic          wreq [2];
  logic [AW-1:0] waddr[2];
  logic [DW-1:0] wdata[2];
  logic [MW-1:0] wmask[2];
  logic [BW-1:0] wbl  [2];
  logic wr0_done, wr1_done;
  logic ram_wr_request, ram_wr_done, busy, owner;
  logic [AW-1:0] ram_wr_address;
  logic [DW-1:0] ram_wr_data;
  logic [MW-1:0] ram_wr_mask;
  logic [BW-1:0] ram_wr_burst_length;

  ram_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .BURST_WIDTH(BW)) dut (
    .clk(clk), .reset(reset),
    .wr0_request(wreq[0]), .wr0_address(waddr[0]), .wr0_data(wdata[0]),
    .wr0_mask(wmask[0]), .wr0_burst_length(wbl[0]), .wr0_done(wr0_done),
    .wr1_request(wreq[1]), .wr1_address(waddr[1]), .wr1_data(wdata[1]),
    .wr1_mask(wmask[1]), .wr1_burst_length(wbl[1]), .wr1_done(wr1_done),
    .ram_wr_request(ram_wr_request), .ram_wr_address(ram_wr_address),
    .ram_wr_data(ram_wr_data), .ram_wr_mask(ram_wr_mask),
    .ram_wr_burst_length(ram_wr_burst_length), .ram_wr_done(ram_wr_done),
    .busy(busy), .owner(owner)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: who holds the port (-1 = nobody), cooldown cycles left,
  // most recent grantee and the writer to lose the next tie.
  int m_holder = -1;
  int m_cool   = 0;
  int m_owner  = 0;
  int m_last   = 1;

  // Stimulus-side state for the writers and the ram model.
  int  gap[2];
  bit  seen_done[2];
  bit  prev_reset;
  bit  obs_req;
  int  ram_cnt, ram_lat;
  int  grants[2];
  int  dones[2];

  task automatic model_step();
    if (reset) begin
      m_holder = -1; m_cool = 0; m_owner = 0; m_last = 1;
    end else if (m_holder >= 0) begin
      if (ram_wr_done || !wreq[m_holder]) begin
        m_holder = -1;
        m_cool   = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (wreq[0] || wreq[1]) begin
      int w;
      if (wreq[0] && wreq[1]) w = 1 - m_last;
      else                    w = wreq[0] ? 0 : 1;
      m_owner  = w;
      m_last   = w;
      m_holder = w;
      grants[w]++;
    end
  endtask

  task automatic drive(input int cyc);
    reset = (cyc < 2) || ($urandom % 400 == 0);
    for (int n = 0; n < 2; n++) begin
      if (prev_reset) begin
        wreq[n] = 1'b0;
        gap[n]  = 0;
      end else if (wreq[n]) begin
        if (seen_done[n]) begin
          wreq[n] = 1'b0;
          gap[n]  = $urandom_range(0, 2);
        end else if ($urandom % 60 == 0) begin
          wreq[n] = 1'b0;
          gap[n]  = $urandom_range(0, 3);
        end
      end else if (gap[n] > 0) begin
        gap[n]--;
      end else if ($urandom % 3 == 0) begin
        wreq[n]  = 1'b1;
        waddr[n] = AW'($urandom);
        wmask[n] = MW'($urandom);
        wbl[n]   = BW'($urandom);
      end
      wdata[n] = $urandom;
    end
    ram_wr_done = 1'b0;
    if (prev_reset) begin
      ram_cnt = 0;
    end else if (obs_req) begin
      ram_cnt++;
      if (ram_cnt >= ram_lat) begin
        ram_wr_done = 1'b1;
        ram_cnt     = 0;
        ram_lat     = $urandom_range(1, 12);
      end
    end else begin
      ram_cnt     = 0;
      ram_wr_done = ($urandom % 25 == 0);
    end
  endtask

  task automatic compare();
    logic e_req, e_d0, e_d1, e_busy;
    e_req  = (m_holder >= 0) ? wreq[m_holder] : 1'b0;
    e_d0   = (m_holder == 0) && ram_wr_done;
    e_d1   = (m_holder == 1) && ram_wr_done;
    e_busy = (m_holder >= 0) || (m_cool > 0);
    check("ram_wr_request", 64'(ram_wr_request), 64'(e_req));
    check("wr0_done", 64'(wr0_done), 64'(e_d0));
    check("wr1_done", 64'(wr1_done), 64'(e_d1));
    check("busy", 64'(busy), 64'(e_busy));
    check("owner", 64'(owner), 64'(m_owner));
    check("ram_wr_address", 64'(ram_wr_address), 64'(waddr[m_owner]));
    check("ram_wr_data", 64'(ram_wr_data), 64'(wdata[m_owner]));
    check("ram_wr_mask", 64'(ram_wr_mask), 64'(wmask[m_owner]));
    check("ram_wr_burst_length", 64'(ram_wr_burst_length), 64'(wbl[m_owner]));
    seen_done[0] = e_d0;
    seen_done[1] = e_d1;
    if (e_d0) dones[0]++;
    if (e_d1) dones[1]++;
    obs_req = ram_wr_request;
  endtask

  initial begin
    reset = 1'b1;
    ram_wr_done = 1'b0;
    for (int n = 0; n < 2; n++) begin
      wreq[n] = 1'b0; waddr[n] = '0; wdata[n] = '0; wmask[n] = '0; wbl[n] = '0;
      gap[n] = 0; seen_done[n] = 1'b0; grants[n] = 0; dones[n] = 0;
    end
    prev_reset = 1'b1;
    obs_req    = 1'b0;
    ram_cnt    = 0;
    ram_lat    = 4;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      drive(cyc);
      #1;
      if (cyc >= 1) compare();
      @(posedge clk);
      model_step();
      prev_reset = reset;
    end
    $display("grants w0=%0d w1=%0d dones w0=%0d w1=%0d", grants[0], grants[1], dones[0], dones[1]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
